// File: rtl/store_pkg.sv
// Shared types for the store packer: request size encoding and FSM states.
package store_pkg;

    localparam int LANES     = 4;
    localparam int WORD_BITS = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BEAT1  = 2'b01,
        BEAT2  = 2'b10,
        FINISH = 2'b11
    } state_e;

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane placement: byte enables and lane-positioned data for the
// first beat and, when the store crosses a word boundary, the spill-over beat.
module store_lane_shifter
    import store_pkg::*;
(
    input  logic [1:0]           offset,
    input  logic [WORD_BITS-1:0] wdata,
    input  size_e                size,
    output logic [LANES-1:0]     be1,
    output logic [WORD_BITS-1:0] data1,
    output logic [LANES-1:0]     be2,
    output logic [WORD_BITS-1:0] data2,
    output logic                 misaligned,
    output logic                 illegal
);

    logic [LANES-1:0]       base_be;
    logic [WORD_BITS-1:0]   keep;
    logic [2*LANES-1:0]     be_wide;
    logic [2*WORD_BITS-1:0] data_wide;

    always_comb begin
        base_be = '0;
        keep    = '0;
        case (size)
            SZ_B:    begin base_be = 4'b0001; keep = 32'h0000_00FF; end
            SZ_H:    begin base_be = 4'b0011; keep = 32'h0000_FFFF; end
            SZ_W:    begin base_be = 4'b1111; keep = 32'hFFFF_FFFF; end
            default: begin base_be = 4'b0000; keep = 32'h0000_0000; end
        endcase
        // Shift into a double-word window; the upper half is what spills past the word.
        be_wide   = {{LANES{1'b0}}, base_be} << offset;
        data_wide = {{WORD_BITS{1'b0}}, wdata & keep} << {offset, 3'b000};
    end

    assign be1        = be_wide[LANES-1:0];
    assign be2        = be_wide[2*LANES-1:LANES];
    assign data1      = data_wide[WORD_BITS-1:0];
    assign data2      = data_wide[2*WORD_BITS-1:WORD_BITS];
    assign misaligned = ((size == SZ_H) && (offset == 2'd3)) ||
                        ((size == SZ_W) && (offset != 2'd0));
    assign illegal    = (size == SZ_ILL);

endmodule

// File: rtl/store_packer.sv
// Store packer: turns SB/SH/SW requests into word-aligned bus beats with byte
// enables. Define STORE_PACKER_MISALIGNED_SPLIT_EN to split boundary-crossing stores.
module store_packer
    import store_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [1:0]           req_size,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [31:0]          bus_addr,
    output logic [31:0]          bus_wdata,
    output logic [LANES-1:0]     bus_be,
    output logic                 done,
    output logic                 err
);

`ifdef STORE_PACKER_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_e             state;
    logic [LANES-1:0]   be1, be2, pend_be;
    logic [31:0]        data1, data2, pend_data;
    logic               misaligned, illegal, split_q;

    store_lane_shifter u_shifter (
        .offset     (req_addr[1:0]),
        .wdata      (req_wdata),
        .size       (size_e'(req_size)),
        .be1        (be1),
        .data1      (data1),
        .be2        (be2),
        .data2      (data2),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            pend_be   <= '0;
            pend_data <= '0;
            split_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        // Rejected requests never leave IDLE; err is the only trace.
                        if (illegal || (misaligned && !SPLIT_EN)) begin
                            err <= 1'b1;
                        end else begin
                            state     <= BEAT1;
                            req_ready <= 1'b0;
                            bus_valid <= 1'b1;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_wdata <= data1;
                            bus_be    <= be1;
                            pend_be   <= be2;
                            pend_data <= data2;
                            split_q   <= misaligned && SPLIT_EN;
                        end
                    end
                end
                BEAT1: begin
                    if (bus_ready) begin
                        if (split_q) begin
                            state     <= BEAT2;
                            bus_addr  <= bus_addr + 32'd4;
                            bus_wdata <= pend_data;
                            bus_be    <= pend_be;
                        end else begin
                            state     <= FINISH;
                            done      <= 1'b1;
                            bus_valid <= 1'b0;
                            bus_addr  <= '0;
                            bus_wdata <= '0;
                            bus_be    <= '0;
                        end
                    end
                end
                BEAT2: begin
                    if (bus_ready) begin
                        state     <= FINISH;
                        done      <= 1'b1;
                        bus_valid <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_be    <= '0;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    split_q   <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer with a byte-level reference model and a
// per-cycle bus monitor.
module tb_store_packer;

`ifdef STORE_PACKER_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        done;
    logic        err;

    int    total = 0;
    int    passed = 0;
    beat_t exp_q[$];
    beat_t mdl_q[$];

    store_packer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Walk the store byte by byte; each byte lands in the word containing its address.
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                         output bit e);
        int          n;
        logic [31:0] ba, w;
        logic [1:0]  lane;
        beat_t       cur;
        bit          have;
        mdl_q.delete();
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || (((int'(a[1:0]) + n) > 4) && !SPLIT);
        if (e) return;
        have = 1'b0;
        cur  = '{addr: '0, be: '0, data: '0};
        for (int i = 0; i < n; i++) begin
            ba   = a + i;
            w    = ba & 32'hFFFF_FFFC;
            lane = ba[1:0];
            if (have && cur.addr != w) begin
                mdl_q.push_back(cur);
                have = 1'b0;
            end
            if (!have) begin
                cur  = '{addr: w, be: 4'b0000, data: 32'h0};
                have = 1'b1;
            end
            cur.be[lane] = 1'b1;
            cur.data[8*lane +: 8] = wd[8*i +: 8];
        end
        if (have) mdl_q.push_back(cur);
    endtask

    // Bus monitor: every visible beat must match the model's next beat and hold under stall.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [3:0]  prev_be;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'b0, bus_valid}, 32'd1);
                chk("hold_addr", bus_addr, prev_addr);
                chk("hold_be", {28'b0, bus_be}, {28'b0, prev_be});
                chk("hold_data", bus_wdata, prev_data);
            end
            if (bus_valid) begin
                chk("busy_ready", {31'b0, req_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {31'b0, bus_valid}, 32'd0);
                end else begin
                    chk("beat_addr", bus_addr, exp_q[0].addr);
                    chk("beat_be", {28'b0, bus_be}, {28'b0, exp_q[0].be});
                    chk("beat_data", bus_wdata, exp_q[0].data);
                    if (bus_ready) void'(exp_q.pop_front());
                end
            end
            prev_stall = bus_valid && !bus_ready;
            prev_addr  = bus_addr;
            prev_be    = bus_be;
            prev_data  = bus_wdata;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        bit rdy;
        rdy = 1'b0;
        for (int k = 0; k < 20 && !rdy; k++) begin
            @(negedge clk);
            rdy = req_ready;
        end
        chk("req_ready_wait", {31'b0, rdy}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_size  = sz;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                            input int stall);
        bit e;
        int ndone, nerr, cyc;
        model(a, wd, sz, e);
        exp_q = mdl_q;
        issue(a, wd, sz);
        bus_ready = (stall == 0);
        ndone = 0;
        nerr  = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (err) begin
                nerr++;
                chk("err_timing", cyc, 1);
            end
            if (done) ndone++;
            if (done || err) break;
            @(posedge clk);
            #1 bus_ready = (cyc >= stall);
        end
        chk("response_seen", ndone + nerr, 1);
        chk("done_expected", ndone, {31'b0, !e});
        chk("err_expected", nerr, {31'b0, e});
        chk("beats_left", exp_q.size(), 0);
        @(posedge clk);
        #1 bus_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("err_pulse", {31'b0, err}, 32'd0);
        chk("ready_after", {31'b0, req_ready}, 32'd1);
        chk("idle_valid", {31'b0, bus_valid}, 32'd0);
    endtask

    initial begin
        bit e;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'b0, bus_valid}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_data", bus_wdata, 32'd0);
        chk("rst_be", {28'b0, bus_be}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // Hand-computed expectations that pin the model itself.
        model(32'h0000_1002, 32'hAABB_CCDD, 2'd0, e);
        chk("pin_sb_n", mdl_q.size(), 1);
        chk("pin_sb_addr", mdl_q[0].addr, 32'h0000_1000);
        chk("pin_sb_be", {28'b0, mdl_q[0].be}, 32'h4);
        chk("pin_sb_data", mdl_q[0].data, 32'h00DD_0000);
        model(32'h0000_2000, 32'h1234_5678, 2'd2, e);
        chk("pin_sw_be", {28'b0, mdl_q[0].be}, 32'hF);
        chk("pin_sw_data", mdl_q[0].data, 32'h1234_5678);
        model(32'h0000_3001, 32'h1122_3344, 2'd2, e);
        if (SPLIT) begin
            chk("pin_split_n", mdl_q.size(), 2);
            chk("pin_split_b1", mdl_q[0].data, 32'h2233_4400);
            chk("pin_split_be1", {28'b0, mdl_q[0].be}, 32'hE);
            chk("pin_split_a2", mdl_q[1].addr, 32'h0000_3004);
            chk("pin_split_b2", mdl_q[1].data, 32'h0000_0011);
            chk("pin_split_be2", {28'b0, mdl_q[1].be}, 32'h1);
            model(32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1, e);
            chk("pin_wrap_a1", mdl_q[0].addr, 32'hFFFF_FFFC);
            chk("pin_wrap_d1", mdl_q[0].data, 32'hEF00_0000);
            chk("pin_wrap_a2", mdl_q[1].addr, 32'h0000_0000);
            chk("pin_wrap_d2", mdl_q[1].data, 32'h0000_00BE);
        end else begin
            chk("pin_nosplit_err", {31'b0, e}, 32'd1);
        end

        do_store(32'h0000_1002, 32'hAABB_CCDD, 2'd0, 0);
        do_store(32'h0000_2000, 32'h1234_5678, 2'd2, 3);
        do_store(32'h0000_1001, 32'hCAFE_F00D, 2'd1, 1);
        do_store(32'h0000_1003, 32'h0000_0055, 2'd0, 0);
        do_store(32'h0000_3001, 32'h1122_3344, 2'd2, 0);
        do_store(32'hFFFF_FFFF, 32'h0000_BEEF, 2'd1, 2);
        do_store(32'h0000_5000, 32'h0BAD_0BAD, 2'd3, 0);
        do_store(32'h0000_6002, 32'h1234_ABCD, 2'd1, 0);
        do_store(32'h0000_7003, 32'hDEAD_BEEF, 2'd2, 1);

        // Reset mid-operation: stall in BEAT2 (split build) or BEAT1, then reset.
        model(SPLIT ? 32'h0000_4002 : 32'h0000_4000, 32'hA1B2_C3D4, 2'd2, e);
        exp_q = mdl_q;
        issue(SPLIT ? 32'h0000_4002 : 32'h0000_4000, 32'hA1B2_C3D4, 2'd2);
        bus_ready = SPLIT;
        @(posedge clk);
        #1 bus_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, bus_valid}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_valid", {31'b0, bus_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_done", {31'b0, done}, 32'd0);
            chk("post_rst_err", {31'b0, err}, 32'd0);
        end

        do_store(32'h0000_8001, 32'h0000_7788, 2'd1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
